// File: rtl/crp16_alu_mc.sv
// CRP16 ALU with single-cycle arithmetic, logic and shift operations and an
// iterative shift-and-add unsigned multiplier that keeps busy high while it runs.
module crp16_alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       select,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MULU = 4'b0101;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_next;
    logic                 accept;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [SHW-1:0]       count;

    logic [WIDTH:0]       sum_add;
    logic [WIDTH:0]       sum_sub;
    logic [SHW-1:0]       sh;
    logic [WIDTH-1:0]     res;
    logic                 res_v, res_c, res_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        mul_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (select == OP_MULU) state_next = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (count == SHW'(WIDTH - 1)) begin
                    mul_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result and flags, computed straight from the inputs being accepted.
    always_comb begin
        res     = '0;
        res_v   = 1'b0;
        res_c   = 1'b0;
        res_n   = 1'b0;
        sh      = y[SHW-1:0];
        sum_add = {1'b0, x} + {1'b0, y};
        sum_sub = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        case (select)
            4'b0000: {res_c, res} = sum_add;
            4'b0001: {res_c, res} = sum_sub;
            4'b0010: begin
                res   = sum_add[WIDTH-1:0];
                res_n = res[WIDTH-1];
                res_v = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
            end
            4'b0011: begin
                res   = sum_sub[WIDTH-1:0];
                res_n = res[WIDTH-1];
                res_v = (x[WIDTH-1] != y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
            end
            4'b0100: res = {{(WIDTH-1){1'b0}}, (x < y)};
            4'b0110: res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            4'b1000: res = x & y;
            4'b1001: res = x | y;
            4'b1010: res = x ^ y;
            4'b1011: res = ~x;
            4'b1100: res = x << sh;
            4'b1101: res = x >> sh;
            4'b1110: res = $signed(x) >>> sh;
            default: res = '0;
        endcase
    end

    assign acc_next = mul_b[0] ? (acc + mul_a) : acc;

    // Multiplier operands are latched at accept so later input changes are harmless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_a   <= '0;
            mul_b   <= '0;
            acc     <= '0;
            count   <= '0;
            alu_out <= '0;
            v       <= 1'b0;
            c       <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (select == OP_MULU) begin
                    mul_a <= {{WIDTH{1'b0}}, x};
                    mul_b <= y;
                    acc   <= '0;
                    count <= '0;
                end else begin
                    alu_out <= res;
                    v       <= res_v;
                    c       <= res_c;
                    n       <= res_n;
                    z       <= (res == '0);
                    done    <= 1'b1;
                end
            end else if (busy) begin
                acc   <= acc_next;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                count <= count + SHW'(1);
                if (mul_last) begin
                    alu_out <= acc_next[WIDTH-1:0];
                    v       <= 1'b0;
                    c       <= |acc_next[2*WIDTH-1:WIDTH];
                    n       <= 1'b0;
                    z       <= (acc_next[WIDTH-1:0] == '0);
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crp16_alu_mc.sv
// Directed-vector bench for crp16_alu_mc: a 16-bit instance for most checks
// and an 8-bit instance for the narrow set-less-than cases.
module tb_crp16_alu_mc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] x16 = '0, y16 = '0;
    logic [3:0]  sel16 = '0;
    logic        start16 = 1'b0;
    logic        busy16, done16, v16, c16, n16, z16;
    logic [15:0] out16;

    logic [7:0]  x8 = '0, y8 = '0;
    logic [3:0]  sel8 = '0;
    logic        start8 = 1'b0;
    logic        busy8, done8, v8, c8, n8, z8;
    logic [7:0]  out8;

    int vec_count   = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  vcnz;
    } vec_t;

    vec_t vecs[20];

    crp16_alu_mc #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .x(x16), .y(y16), .select(sel16),
        .start(start16), .busy(busy16), .done(done16), .alu_out(out16),
        .v(v16), .c(c16), .n(n16), .z(z16)
    );

    crp16_alu_mc #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .x(x8), .y(y8), .select(sel8),
        .start(start8), .busy(busy8), .done(done8), .alu_out(out8),
        .v(v8), .c(c8), .n(n8), .z(z8)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    // Presents one request for a single edge; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input bit narrow, input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        if (narrow) begin
            x8 = a[7:0]; y8 = b[7:0]; sel8 = sel; start8 = 1'b1;
        end else begin
            x16 = a; y16 = b; sel16 = sel; start16 = 1'b1;
        end
        @(posedge clock);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt, done_cyc;

        vecs[0]  = '{4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
        vecs[1]  = '{4'b0001, 16'h0005, 16'h0005, 16'h0000, 4'b0101};
        vecs[2]  = '{4'b0001, 16'h0004, 16'h0005, 16'hFFFF, 4'b0000};
        vecs[3]  = '{4'b1110, 16'h8000, 16'h0013, 16'hF000, 4'b0000};
        vecs[4]  = '{4'b1101, 16'h8000, 16'h0013, 16'h1000, 4'b0000};
        vecs[5]  = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
        vecs[6]  = '{4'b0011, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000};
        vecs[7]  = '{4'b1000, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
        vecs[8]  = '{4'b1001, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0000};
        vecs[9]  = '{4'b1010, 16'hAAAA, 16'hFFFF, 16'h5555, 4'b0000};
        vecs[10] = '{4'b1011, 16'h1234, 16'h0000, 16'hEDCB, 4'b0000};
        vecs[11] = '{4'b1100, 16'h0001, 16'h00F4, 16'h0010, 4'b0000};
        vecs[12] = '{4'b1100, 16'hABCD, 16'h0010, 16'hABCD, 4'b0000};
        vecs[13] = '{4'b0111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001};
        vecs[14] = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 4'b0001};
        vecs[15] = '{4'b0100, 16'h0001, 16'h8000, 16'h0001, 4'b0000};
        vecs[16] = '{4'b0110, 16'h8000, 16'h0001, 16'h0001, 4'b0000};
        vecs[17] = '{4'b0110, 16'h0001, 16'h8000, 16'h0000, 4'b0001};
        vecs[18] = '{4'b0010, 16'hFFFF, 16'h0001, 16'h0000, 4'b0001};
        vecs[19] = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0000};

        #1;
        checkOutput("reset alu_out", 32'(out16), 32'h0);
        checkOutput("reset vcnz", 32'({v16, c16, n16, z16}), 32'h0);
        checkOutput("reset busy/done", 32'({busy16, done16}), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, vecs[i].sel, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d alu_out", i), 32'(out16), 32'(vecs[i].res));
            checkOutput($sformatf("vec%0d vcnz", i), 32'({v16, c16, n16, z16}), 32'(vecs[i].vcnz));
            checkOutput($sformatf("vec%0d busy/done", i), 32'({busy16, done16}), 32'b01);
            @(posedge clock);
            #1;
            checkOutput($sformatf("vec%0d done pulse", i), 32'(done16), 32'h0);
            checkOutput($sformatf("vec%0d hold", i), 32'(out16), 32'(vecs[i].res));
        end

        // Multiply with an ignored mid-operation start.
        applyStimulus(1'b0, 4'b0101, 16'h0100, 16'h0100);
        busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy16) busy_cnt++;
            if (done16) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 8) begin
                x16 = 16'h0001; y16 = 16'h0001; sel16 = 4'b0000; start16 = 1'b1;
            end
            if (cyc == 9) start16 = 1'b0;
            @(posedge clock);
            #1;
        end
        checkOutput("mulu busy cycles", 32'(busy_cnt), 32'd16);
        checkOutput("mulu done cycle", 32'(done_cyc), 32'd17);
        checkOutput("mulu done count", 32'(done_cnt), 32'd1);
        checkOutput("mulu alu_out", 32'(out16), 32'h0);
        checkOutput("mulu vcnz", 32'({v16, c16, n16, z16}), 32'b0101);

        // Multiply with low product and no high part.
        applyStimulus(1'b0, 4'b0101, 16'h0123, 16'h0011);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 20 && done_cnt == 0; cyc++) begin
            @(posedge clock);
            #1;
            if (done16) done_cnt++;
        end
        checkOutput("mulu2 done seen", 32'(done_cnt), 32'd1);
        checkOutput("mulu2 alu_out", 32'(out16), 32'h1353);
        checkOutput("mulu2 vcnz", 32'({v16, c16, n16, z16}), 32'b0000);
        @(posedge clock);
        #1;

        // Reset in the middle of a multiply.
        applyStimulus(1'b0, 4'b0011, 16'h8000, 16'h0001);
        checkOutput("pre-reset alu_out", 32'(out16), 32'h7FFF);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 4'b0101, 16'h0003, 16'h0005);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("mulu mid busy", 32'(busy16), 32'h1);
        checkOutput("mulu mid hold alu_out", 32'(out16), 32'h7FFF);
        checkOutput("mulu mid hold vcnz", 32'({v16, c16, n16, z16}), 32'b1000);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset alu_out", 32'(out16), 32'h0);
        checkOutput("async reset vcnz", 32'({v16, c16, n16, z16}), 32'h0);
        checkOutput("async reset busy/done", 32'({busy16, done16}), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1;
            if (done16 || busy16) done_cnt++;
        end
        checkOutput("no done after reset", 32'(done_cnt), 32'h0);
        applyStimulus(1'b0, 4'b0000, 16'h0002, 16'h0003);
        checkOutput("post-reset add alu_out", 32'(out16), 32'h0005);
        checkOutput("post-reset add done", 32'(done16), 32'h1);

        // Narrow instance.
        applyStimulus(1'b1, 4'b0110, 16'h0080, 16'h0001);
        checkOutput("w8 slt alu_out", 32'(out8), 32'h01);
        checkOutput("w8 slt z/done", 32'({z8, done8}), 32'b01);
        applyStimulus(1'b1, 4'b0100, 16'h0080, 16'h0001);
        checkOutput("w8 sltu alu_out", 32'(out8), 32'h00);
        checkOutput("w8 sltu z/done", 32'({z8, done8}), 32'b11);
        applyStimulus(1'b1, 4'b0101, 16'h0013, 16'h0011);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 12 && done_cnt == 0; cyc++) begin
            @(posedge clock);
            #1;
            if (done8) done_cnt = cyc + 1;
        end
        checkOutput("w8 mulu done cycle", 32'(done_cnt), 32'd9);
        checkOutput("w8 mulu alu_out", 32'(out8), 32'h43);
        checkOutput("w8 mulu c", 32'(c8), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
